// File: rtl/ball_serve_ctrl.sv
// Serve controller for a two-player ball game: requests a random serve velocity, launches the ball, scores goals, and holds between points.
// Build option: define AUTO_SERVE_EN to re-serve automatically when the post-goal hold expires.
module ball_serve_ctrl #(
  parameter int DELAY_FRAMES = 60,
  parameter int WIN_SCORE    = 5
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              start,
  input  logic              startOfFrame,
  input  logic              goal_left,
  input  logic              goal_right,
  input  logic signed [2:0] rnd_x,
  input  logic signed [2:0] rnd_y,
  output logic              rnd_rise,
  output logic signed [2:0] ball_xspeed,
  output logic signed [2:0] ball_yspeed,
  output logic              ball_load,
  output logic              ball_en,
  output logic [3:0]        score_left,
  output logic [3:0]        score_right,
  output logic              game_over
);

  typedef enum logic [2:0] {IDLE, REQ, SAMPLE, LAUNCH, PLAY, HOLD, OVER} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_NEG, DIR_POS} dir_t;

  state_t            state_reg, state_next;
  dir_t              dir_reg, dir_next;
  logic [3:0]        score_left_reg, score_left_next;
  logic [3:0]        score_right_reg, score_right_next;
  logic [7:0]        hold_cnt_reg, hold_cnt_next;
  logic signed [2:0] xspeed_reg, xspeed_next;
  logic signed [2:0] yspeed_reg, yspeed_next;
  logic [3:0]        score_left_inc, score_right_inc;

  // Zero becomes magnitude 1, magnitude clamps to 3, then the sign is either
  // kept from the generator or forced by the side that conceded last.
  function automatic logic signed [2:0] fix_speed(input logic signed [2:0] v, input dir_t dir);
    logic [2:0] abs_v;
    logic [2:0] mag;
    logic       neg;
    abs_v = v[2] ? (~v + 3'd1) : v;
    if (abs_v == 3'd0)
      mag = 3'd1;
    else if (abs_v > 3'd3)
      mag = 3'd3;
    else
      mag = abs_v;
    case (dir)
      DIR_NEG: neg = 1'b1;
      DIR_POS: neg = 1'b0;
      default: neg = v[2];
    endcase
    return neg ? (~mag + 3'd1) : mag;
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg       <= IDLE;
      dir_reg         <= DIR_NONE;
      score_left_reg  <= '0;
      score_right_reg <= '0;
      hold_cnt_reg    <= '0;
      xspeed_reg      <= '0;
      yspeed_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      dir_reg         <= dir_next;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
      hold_cnt_reg    <= hold_cnt_next;
      xspeed_reg      <= xspeed_next;
      yspeed_reg      <= yspeed_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    dir_next         = dir_reg;
    score_left_next  = score_left_reg;
    score_right_next = score_right_reg;
    hold_cnt_next    = hold_cnt_reg;
    xspeed_next      = xspeed_reg;
    yspeed_next      = yspeed_reg;
    score_left_inc   = score_left_reg + 4'd1;
    score_right_inc  = score_right_reg + 4'd1;
    case (state_reg)
      IDLE: begin
        if (start)
          state_next = REQ;
      end
      REQ: state_next = SAMPLE;
      SAMPLE: begin
        xspeed_next = fix_speed(rnd_x, dir_reg);
        yspeed_next = fix_speed(rnd_y, DIR_NONE);
        state_next  = LAUNCH;
      end
      LAUNCH: state_next = PLAY;
      PLAY: begin
        // A simultaneous goal pair counts only the left goal.
        if (goal_left) begin
          score_right_next = score_right_inc;
          dir_next         = DIR_NEG;
          hold_cnt_next    = '0;
          state_next       = (score_right_inc == 4'(WIN_SCORE)) ? OVER : HOLD;
        end else if (goal_right) begin
          score_left_next = score_left_inc;
          dir_next        = DIR_POS;
          hold_cnt_next   = '0;
          state_next      = (score_left_inc == 4'(WIN_SCORE)) ? OVER : HOLD;
        end
      end
      HOLD: begin
        if (startOfFrame) begin
          if (hold_cnt_reg == 8'(DELAY_FRAMES - 1)) begin
            hold_cnt_next = '0;
`ifdef AUTO_SERVE_EN
            state_next    = REQ;
`else
            state_next    = IDLE;
`endif
          end else begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end
      end
      OVER: begin
        if (start) begin
          score_left_next  = '0;
          score_right_next = '0;
          dir_next         = DIR_NONE;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state, so they drop together with the async reset.
  assign rnd_rise    = (state_reg == REQ);
  assign ball_load   = (state_reg == LAUNCH);
  assign ball_en     = (state_reg == LAUNCH) || (state_reg == PLAY);
  assign game_over   = (state_reg == OVER);
  assign ball_xspeed = xspeed_reg;
  assign ball_yspeed = yspeed_reg;
  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;

endmodule
